qspi_mem_ctrl: RTL and testbench



---
 rtl/qspi_mem_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_qspi_mem_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_mem_ctrl.sv
// -----------------------------------------------------------------------------
// qspi_mem_ctrl
//   Memory-side bridge between the FemtoRV32 core bus and a shared QSPI bus
//   with two devices: a read-only flash (region 0) and a PSRAM (region 1).
//   Each accepted core request becomes exactly one QSPI frame:
//     CMD (2 nibbles) -> ADDR (6 nibbles) -> DUMMY (reads) -> DATA (2/4/8)
//   followed by a one-cycle mem_ready pulse. Requests to other regions, and
//   writes to flash, complete on the next edge with mem_rdata = 0.
//
// Ports
//   clk, rst            single clock, asynchronous active-high reset
//   mem_addr            request address; [27:24] region, [23:0] device address
//   mem_wdata           store data (little-endian)
//   mem_write_n         2'b11 none, 00 byte, 01 half, 10 word
//   mem_read_n          same encoding; a write wins if both are asserted
//   mem_rdata           right-justified read data, held until next completion
//   mem_ready           one-cycle completion pulse
//   qspi_sck            SPI clock (clk/2 while a frame is active)
//   qspi_cs_flash_n     flash chip select
//   qspi_cs_ram_n       PSRAM chip select
//   qspi_data_out/oe    IO drive value / per-bit output enables
//   qspi_data_in        IO sampled value
// -----------------------------------------------------------------------------
module qspi_mem_ctrl #(
    parameter int         ADDR_WIDTH     = 28,
    parameter int         FLASH_DUMMY    = 4,
    parameter int         RAM_DUMMY      = 6,
    parameter logic [7:0] FLASH_READ_CMD = 8'hEB,
    parameter logic [7:0] RAM_READ_CMD   = 8'hEB,
    parameter logic [7:0] RAM_WRITE_CMD  = 8'h38
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [1:0]            mem_write_n,
    input  logic [1:0]            mem_read_n,
    output logic [31:0]           mem_rdata,
    output logic                  mem_ready,
    output logic                  qspi_sck,
    output logic                  qspi_cs_flash_n,
    output logic                  qspi_cs_ram_n,
    output logic [3:0]            qspi_data_out,
    output logic [3:0]            qspi_data_oe,
    input  logic [3:0]            qspi_data_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_SKIP,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        sck_q, sck_d;
    logic        cs_flash_n_q, cs_flash_n_d;
    logic        cs_ram_n_q, cs_ram_n_d;
    logic [3:0]  data_out_q, data_out_d;
    logic [3:0]  data_oe_q, data_oe_d;
    logic        mem_ready_q, mem_ready_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_write_q, is_write_d;
    logic        is_flash_q, is_flash_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] tx_q, tx_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rx_q, rx_d;

    logic        wr_req, rd_req, req;
    logic [1:0]  req_size;
    logic [3:0]  region;
    logic [4:0]  dummy_len;
    logic [3:0]  data_last;
    logic [4:0]  rx_base;

    // Reorders the store word so that shifting right by one nibble at a time
    // emits byte 0 first and, within each byte, the high nibble first.
    function automatic logic [31:0] nibble_swap(input logic [31:0] w);
        return {w[27:24], w[31:28], w[19:16], w[23:20],
                w[11:8],  w[15:12], w[3:0],   w[7:4]};
    endfunction

    assign wr_req    = (mem_write_n != 2'b11);
    assign rd_req    = (mem_read_n != 2'b11);
    assign req       = wr_req | rd_req;
    assign req_size  = wr_req ? mem_write_n : mem_read_n;
    assign region    = mem_addr[27:24];
    assign dummy_len = is_flash_q ? 5'(FLASH_DUMMY) : 5'(RAM_DUMMY);
    assign data_last = (size_q == 2'b00) ? 4'd1 : (size_q == 2'b01) ? 4'd3 : 4'd7;
    // Received nibble k lands in byte k/2; even k is the high nibble.
    assign rx_base   = {cnt_q[2:1], ~cnt_q[0], 2'b00};

    always_comb begin
        state_d      = state_q;
        sck_d        = sck_q;
        cs_flash_n_d = cs_flash_n_q;
        cs_ram_n_d   = cs_ram_n_q;
        data_out_d   = data_out_q;
        data_oe_d    = data_oe_q;
        mem_ready_d  = 1'b0;
        mem_rdata_d  = mem_rdata_q;
        cnt_d        = cnt_q;
        is_write_d   = is_write_q;
        is_flash_d   = is_flash_q;
        size_d       = size_q;
        tx_d         = tx_q;
        wd_d         = wd_q;
        rx_d         = rx_q;

        case (state_q)
            S_IDLE: begin
                // The core still presents the finished request while
                // mem_ready is high, so it must not be taken again.
                if (!mem_ready_q && req) begin
                    is_write_d = wr_req;
                    size_d     = req_size;
                    is_flash_d = (region == 4'd0);
                    wd_d       = nibble_swap(mem_wdata);
                    rx_d       = '0;
                    cnt_d      = '0;
                    sck_d      = 1'b0;
                    if (region == 4'd0 && !wr_req) begin
                        state_d      = S_CMD;
                        cs_flash_n_d = 1'b0;
                        data_oe_d    = 4'hF;
                        tx_d         = {FLASH_READ_CMD, mem_addr[23:0]};
                        data_out_d   = tx_d[31:28];
                    end else if (region == 4'd1) begin
                        state_d    = S_CMD;
                        cs_ram_n_d = 1'b0;
                        data_oe_d  = 4'hF;
                        tx_d       = {(wr_req ? RAM_WRITE_CMD : RAM_READ_CMD), mem_addr[23:0]};
                        data_out_d = tx_d[31:28];
                    end else begin
                        state_d = S_SKIP;
                    end
                end
            end

            // In every frame state sck toggles each clk; work happens on the
            // edge that ends the high phase (sck_q == 1), which also starts
            // the next low phase where data_out may change.
            S_CMD: begin
                sck_d = ~sck_q;
                if (sck_q) begin
                    tx_d       = tx_q << 4;
                    data_out_d = tx_q[27:24];
                    cnt_d      = cnt_q + 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_ADDR;
                        cnt_d   = '0;
                    end
                end
            end

            S_ADDR: begin
                sck_d = ~sck_q;
                if (sck_q) begin
                    tx_d       = tx_q << 4;
                    data_out_d = tx_q[27:24];
                    cnt_d      = cnt_q + 4'd1;
                    if (cnt_q == 4'd5) begin
                        cnt_d = '0;
                        if (is_write_q) begin
                            state_d    = S_DATA;
                            data_out_d = wd_q[3:0];
                        end else begin
                            data_oe_d  = 4'h0;
                            data_out_d = 4'h0;
                            state_d    = (dummy_len == 5'd0) ? S_DATA : S_DUMMY;
                        end
                    end
                end
            end

            S_DUMMY: begin
                sck_d = ~sck_q;
                if (sck_q) begin
                    cnt_d = cnt_q + 4'd1;
                    if ({1'b0, cnt_q} == dummy_len - 5'd1) begin
                        cnt_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                sck_d = ~sck_q;
                if (sck_q) begin
                    cnt_d = cnt_q + 4'd1;
                    if (is_write_q) begin
                        wd_d       = wd_q >> 4;
                        data_out_d = wd_q[7:4];
                    end else begin
                        rx_d[rx_base +: 4] = qspi_data_in;
                    end
                    if (cnt_q == data_last) begin
                        state_d      = S_DONE;
                        cs_flash_n_d = 1'b1;
                        cs_ram_n_d   = 1'b1;
                        sck_d        = 1'b0;
                        data_oe_d    = 4'h0;
                        data_out_d   = 4'h0;
                        mem_ready_d  = 1'b1;
                        mem_rdata_d  = rx_d;
                    end
                end
            end

            // Unmapped region or flash write: complete without touching the bus.
            S_SKIP: begin
                state_d     = S_DONE;
                mem_ready_d = 1'b1;
                mem_rdata_d = '0;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sck_q        <= 1'b0;
            cs_flash_n_q <= 1'b1;
            cs_ram_n_q   <= 1'b1;
            data_out_q   <= 4'h0;
            data_oe_q    <= 4'h0;
            mem_ready_q  <= 1'b0;
            mem_rdata_q  <= '0;
            cnt_q        <= '0;
            is_write_q   <= 1'b0;
            is_flash_q   <= 1'b0;
            size_q       <= 2'b00;
        end else begin
            state_q      <= state_d;
            sck_q        <= sck_d;
            cs_flash_n_q <= cs_flash_n_d;
            cs_ram_n_q   <= cs_ram_n_d;
            data_out_q   <= data_out_d;
            data_oe_q    <= data_oe_d;
            mem_ready_q  <= mem_ready_d;
            mem_rdata_q  <= mem_rdata_d;
            cnt_q        <= cnt_d;
            is_write_q   <= is_write_d;
            is_flash_q   <= is_flash_d;
            size_q       <= size_d;
        end
    end

    // Shift registers carry data only; they are always reloaded on acceptance.
    always_ff @(posedge clk) begin
        tx_q <= tx_d;
        wd_q <= wd_d;
        rx_q <= rx_d;
    end

    assign mem_rdata       = mem_rdata_q;
    assign mem_ready       = mem_ready_q;
    assign qspi_sck        = sck_q;
    assign qspi_cs_flash_n = cs_flash_n_q;
    assign qspi_cs_ram_n   = cs_ram_n_q;
    assign qspi_data_out   = data_out_q;
    assign qspi_data_oe    = data_oe_q;

endmodule

// File: tb/tb_qspi_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_qspi_mem_ctrl
//   Self-checking bench for qspi_mem_ctrl. Each transaction pushes its expected
//   frame, latency and read data to a scoreboard queue; a cycle-by-cycle
//   monitor plays the QSPI device, captures the frame and pops/compares when
//   mem_ready pulses.
// -----------------------------------------------------------------------------
module tb_qspi_mem_ctrl;

    localparam int FLASH_DUMMY = 4;
    localparam int RAM_DUMMY   = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [27:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_write_n;
    logic [1:0]  mem_read_n;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        qspi_sck;
    logic        qspi_cs_flash_n;
    logic        qspi_cs_ram_n;
    logic [3:0]  qspi_data_out;
    logic [3:0]  qspi_data_oe;
    logic [3:0]  qspi_data_in;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int frames = 0;
    int last_e0;
    int last_ready;

    typedef struct {
        logic [31:0] rdata;
        bit          chk_rd;
        int          lat;
        logic [63:0] tx;
        int          txn;
        int          cs_sel;
    } exp_t;

    exp_t sb[$];

    qspi_mem_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_write_n     (mem_write_n),
        .mem_read_n      (mem_read_n),
        .mem_rdata       (mem_rdata),
        .mem_ready       (mem_ready),
        .qspi_sck        (qspi_sck),
        .qspi_cs_flash_n (qspi_cs_flash_n),
        .qspi_cs_ram_n   (qspi_cs_ram_n),
        .qspi_data_out   (qspi_data_out),
        .qspi_data_oe    (qspi_data_oe),
        .qspi_data_in    (qspi_data_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge qspi_cs_flash_n or negedge qspi_cs_ram_n) frames <= frames + 1;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // Frame as seen on the wire while oe is driven, first nibble most significant.
    function automatic logic [63:0] exp_tx(input logic [7:0] cmd, input logic [23:0] addr,
                                           input bit wr, input logic [1:0] sz,
                                           input logic [31:0] wdata);
        logic [63:0] t;
        t = {32'h0, cmd, addr};
        if (wr) begin
            for (int b = 0; b < nbytes(sz); b++) t = {t[55:0], wdata[8*b +: 8]};
        end
        return t;
    endfunction

    // Device nibble j is rnibs[31-4j -: 4]; pairs form bytes 0,1,2,3.
    function automatic logic [31:0] exp_rdata(input logic [31:0] rnibs, input logic [1:0] sz);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < nbytes(sz); b++)
            r[8*b +: 8] = {rnibs[31-8*b -: 4], rnibs[27-8*b -: 4]};
        return r;
    endfunction

    task automatic idle(input int n);
        mem_write_n = 2'b11;
        mem_read_n  = 2'b11;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle. Leaves the request asserted
    // through the ready cycle and returns at the following negedge.
    task automatic run_txn(input logic [27:0] addr, input bit wr, input logic [1:0] sz,
                           input logic [31:0] wdata, input logic [31:0] rnibs);
        exp_t        e;
        exp_t        o;
        logic [7:0]  cmd;
        int          dummy;
        int          e0;
        int          k;
        int          j;
        int          txn;
        int          csf;
        int          csr;
        bit          both;
        bit          got;
        logic [63:0] tx;

        cmd   = 8'h00;
        dummy = 0;
        if (addr[27:24] == 4'd0 && !wr) begin
            cmd = 8'hEB; dummy = FLASH_DUMMY; e.cs_sel = 1;
        end else if (addr[27:24] == 4'd1) begin
            cmd = wr ? 8'h38 : 8'hEB; dummy = wr ? 0 : RAM_DUMMY; e.cs_sel = 2;
        end else begin
            e.cs_sel = 0;
        end
        if (e.cs_sel != 0) begin
            e.tx     = exp_tx(cmd, addr[23:0], wr, sz, wdata);
            e.txn    = 8 + (wr ? 2 * nbytes(sz) : 0);
            e.lat    = 2 * (8 + dummy + 2 * nbytes(sz));
            e.rdata  = wr ? 32'h0 : exp_rdata(rnibs, sz);
            e.chk_rd = !wr;
        end else begin
            e.tx = '0; e.txn = 0; e.lat = 1; e.rdata = '0; e.chk_rd = 1'b1;
        end
        sb.push_back(e);

        mem_addr  = addr;
        mem_wdata = wdata;
        if (wr) begin
            mem_write_n = sz; mem_read_n = 2'b11;
        end else begin
            mem_write_n = 2'b11; mem_read_n = sz;
        end
        e0 = cyc + 1;
        last_e0 = e0;
        k = 0; txn = 0; csf = 0; csr = 0; both = 1'b0; got = 1'b0; tx = '0;

        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (c == 0 && e.cs_sel != 0)
                check_val("cs_fall_at_accept",
                          64'(e.cs_sel == 1 ? qspi_cs_flash_n : qspi_cs_ram_n), 64'(0));
            if (!qspi_cs_flash_n) csf++;
            if (!qspi_cs_ram_n) csr++;
            if (!qspi_cs_flash_n && !qspi_cs_ram_n) both = 1'b1;
            if ((!qspi_cs_flash_n || !qspi_cs_ram_n) && qspi_sck) begin
                if (qspi_data_oe == 4'hF) begin
                    tx = {tx[59:0], qspi_data_out};
                    txn++;
                end
                j = k - 8 - dummy;
                if (!wr && j >= 0 && j < 8) qspi_data_in = rnibs[31-4*j -: 4];
                else qspi_data_in = 4'hA;
                k++;
            end
            if (mem_ready) got = 1'b1;
        end

        if (!got) begin
            check_val("ready_timeout", 64'(mem_ready), 64'(1));
            void'(sb.pop_front());
        end else begin
            o = sb.pop_front();
            last_ready = cyc;
            check_val("latency", 64'(cyc - e0), 64'(o.lat));
            if (o.chk_rd) check_val("rdata", 64'(mem_rdata), 64'(o.rdata));
            check_val("frame_nibbles", tx, o.tx);
            check_val("frame_len", 64'(txn), 64'(o.txn));
            check_val("cs_low_cycles", {32'(csf), 32'(csr)},
                      {32'(o.cs_sel == 1 ? o.lat : 0), 32'(o.cs_sel == 2 ? o.lat : 0)});
            check_val("cs_exclusive", 64'(both), 64'(0));
            check_val("done_bus_idle",
                      64'({qspi_cs_flash_n, qspi_cs_ram_n, qspi_sck, qspi_data_oe}),
                      64'({1'b1, 1'b1, 1'b0, 4'h0}));
        end
        qspi_data_in = 4'hA;
        @(negedge clk);
        check_val("ready_pulse_width", 64'(mem_ready), 64'(0));
    endtask

    initial begin
        int          f0;
        int          r1;
        bit          saw;
        logic [1:0]  sz;
        logic [27:0] a;

        rst          = 1'b1;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_write_n  = 2'b11;
        mem_read_n   = 2'b11;
        qspi_data_in = 4'hA;
        repeat (3) @(negedge clk);
        check_val("rst_cs", 64'({qspi_cs_flash_n, qspi_cs_ram_n}), 64'(2'b11));
        check_val("rst_sck", 64'(qspi_sck), 64'(0));
        check_val("rst_oe", 64'(qspi_data_oe), 64'(0));
        check_val("rst_dout", 64'(qspi_data_out), 64'(0));
        check_val("rst_ready", 64'(mem_ready), 64'(0));
        check_val("rst_rdata", 64'(mem_rdata), 64'(0));
        rst = 1'b0;
        idle(2);

        // Flash word read
        run_txn(28'h0000104, 1'b0, 2'b10, 32'h0, 32'h44332211);
        check_val("flash_word_value", 64'(mem_rdata), 64'(32'h11223344));
        idle(2);

        // PSRAM byte write
        run_txn(28'h1000013, 1'b1, 2'b00, 32'hDEADBEA5, 32'h0);
        idle(2);

        // PSRAM half read
        run_txn(28'h1000002, 1'b0, 2'b01, 32'h0, 32'h8F700000);
        check_val("ram_half_value", 64'(mem_rdata), 64'(32'h0000708F));
        idle(2);

        // Back-to-back: second request presented right after the ready cycle
        f0 = frames;
        run_txn(28'h0000200, 1'b0, 2'b10, 32'h0, 32'h12345678);
        r1 = last_ready;
        run_txn(28'h1000040, 1'b0, 2'b10, 32'h0, 32'h9ABCDEF0);
        check_val("b2b_cs_gap", 64'(last_e0 - r1), 64'(2));
        idle(4);
        check_val("b2b_frame_count", 64'(frames - f0), 64'(2));

        // Reset in the middle of the ADDR phase of a flash read
        mem_addr   = 28'h0000300;
        mem_read_n = 2'b10;
        repeat (7) @(negedge clk);
        check_val("mid_frame_active", 64'(qspi_cs_flash_n), 64'(0));
        #2 rst = 1'b1;
        #1;
        check_val("arst_cs", 64'({qspi_cs_flash_n, qspi_cs_ram_n}), 64'(2'b11));
        check_val("arst_sck", 64'(qspi_sck), 64'(0));
        check_val("arst_oe", 64'(qspi_data_oe), 64'(0));
        check_val("arst_ready", 64'(mem_ready), 64'(0));
        check_val("arst_rdata", 64'(mem_rdata), 64'(0));
        mem_read_n = 2'b11;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw = saw | mem_ready | ~qspi_cs_flash_n | ~qspi_cs_ram_n;
        end
        check_val("quiet_after_rst", 64'(saw), 64'(0));
        run_txn(28'h0000040, 1'b0, 2'b10, 32'h0, 32'hC0FFEE11);
        idle(2);

        // Flash write and unmapped region read: no bus activity
        f0 = frames;
        run_txn(28'h0000000, 1'b1, 2'b10, 32'hCAFEF00D, 32'h0);
        idle(2);
        run_txn(28'h1000008, 1'b0, 2'b10, 32'h0, 32'h55AA33CC);
        idle(2);
        f0 = frames;
        run_txn(28'h3000010, 1'b0, 2'b10, 32'h0, 32'h0);
        idle(3);
        check_val("no_frame_error_path", 64'(frames - f0), 64'(0));

        // Randomised PSRAM writes/reads and flash reads of every size
        for (int i = 0; i < 4; i++) begin
            sz = 2'($urandom_range(0, 2));
            a  = {4'h1, 24'($urandom)};
            run_txn(a, 1'b1, sz, $urandom, 32'h0);
            idle(1);
            run_txn(a, 1'b0, sz, 32'h0, $urandom);
            idle(1);
            run_txn({4'h0, 24'($urandom)}, 1'b0, 2'($urandom_range(0, 2)), 32'h0, $urandom);
            idle(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
